// File: rtl/riscv_mmio_pkg.sv
// Shared constants and types for the MMIO UART transmitter.
// The state enum widens to 3 bits when UART_PARITY_EN is defined.
package riscv_mmio_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_BUSY   = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_PARITY = 4;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_e;
  localparam logic PARITY_EN = 1'b1;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;
  localparam logic PARITY_EN = 1'b0;
`endif

endpackage

// File: rtl/riscv_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is accepted
// only if a pop happens in the same cycle.
module riscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/riscv_mmio_uart_tx.sv
// MMIO console transmitter: TXDATA/STATUS registers, TX FIFO and 8N1 serializer.
// Defining UART_PARITY_EN adds an even-parity bit before the stop bit.
module riscv_mmio_uart_tx
  import riscv_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              tx,
  output logic              irq_empty
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_e   state, state_nxt;
  logic [CW-1:0] cyc_cnt, cyc_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic        par_bit, par_nxt;
  logic        tx_nxt;
  logic        bit_end;
  logic        overflow;

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic [ADDR_W-1:0] word_addr;
  logic        hit_tx, hit_status, push_req, ovf_set, ovf_clr;
  logic [31:0] status;
  logic        unused;

  assign word_addr  = {addr[ADDR_W-1:2], 2'b00};
  assign hit_tx     = sel && (word_addr == ADDR_W'(OFF_TXDATA));
  assign hit_status = sel && (word_addr == ADDR_W'(OFF_STATUS));
  assign push_req   = hit_tx && we;
  assign ovf_set    = push_req && fifo_full && !fifo_pop;
  assign ovf_clr    = hit_status && we && wdata[ST_OVF];
  assign irq_empty  = fifo_empty && (state == S_IDLE);
  assign unused     = ^{wdata[31:8], wdata[2:0], addr[1:0], fifo_count, par_bit};

  riscv_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (fifo_pop),
    .wdata (wdata[7:0]),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // STATUS is built from pre-edge state, so a read sees the value before any push/pop.
  always_comb begin
    status            = '0;
    status[ST_FULL]   = fifo_full;
    status[ST_EMPTY]  = fifo_empty;
    status[ST_BUSY]   = (state != S_IDLE);
    status[ST_OVF]    = overflow;
    status[ST_PARITY] = PARITY_EN;
  end

  assign bit_end = (cyc_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_nxt = state;
    cyc_nxt   = bit_end ? '0 : cyc_cnt + CW'(1);
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    par_nxt   = par_bit;
    fifo_pop  = 1'b0;
    tx_nxt    = 1'b1;
    case (state)
      S_IDLE: begin
        cyc_nxt = '0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shreg_nxt = fifo_head;
          par_nxt   = ^fifo_head;
          bit_nxt   = '0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        tx_nxt = 1'b0;
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        tx_nxt = shreg[0];
        if (bit_end) begin
          shreg_nxt = {1'b0, shreg[7:1]};
          bit_nxt   = bit_cnt + 3'd1;
`ifdef UART_PARITY_EN
          if (bit_cnt == 3'd7) state_nxt = S_PARITY;
`else
          if (bit_cnt == 3'd7) state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        tx_nxt = par_bit;
        if (bit_end) state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // tx is registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      overflow <= 1'b0;
      rdata    <= '0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      par_bit <= par_nxt;
      tx      <= tx_nxt;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (sel && re)    rdata <= hit_status ? status : 32'd0;
    end
  end

endmodule

// File: tb/tb_riscv_mmio_uart_tx.sv
// Bench for riscv_mmio_uart_tx: queue/timeline reference model, per-cycle
// compare, a line receiver feeding a scoreboard, and directed literal checks.
`timescale 1ns/1ps
module tb_riscv_mmio_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 4;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
  localparam logic [31:0] PAR_BIT = 32'h10;
`else
  localparam int FB = 10;
  localparam logic [31:0] PAR_BIT = 32'h0;
`endif
  localparam int FL = FB * CPB;

  // clock/reset and bus signals
  logic          clk = 1'b1;
  logic          rst = 1'b0;
  logic          sel = 1'b0;
  logic          we  = 1'b0;
  logic          re  = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          tx;
  logic          irq_empty;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .we        (we),
    .re        (re),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: byte queue plus the edge at which the current frame was popped
  logic [7:0]  m_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_log[$];
  int          cyc = 0;
  int          last_pop = -1000;
  logic [7:0]  cur_byte = '0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_rdata = '0;

  function automatic logic busy_at(input int k);
    return ((k - last_pop) >= 0) && ((k - last_pop) < FL);
  endfunction

  function automatic logic model_tx(input int k);
    int off;
    int idx;
    off = k - 1 - last_pop;
    if (off < 0 || off >= FL) return 1'b1;
    idx = off / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return cur_byte[idx-1];
    if (FB == 11 && idx == 9) return ^cur_byte;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model_step
    logic [31:0] st;
    logic        pop_now;
    logic        set_ovf;
    logic [1:0]  word;
    cyc++;
    word    = addr[3:2];
    set_ovf = 1'b0;
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      last_pop = -1000;
      m_ovf    = 1'b0;
      m_rdata  = '0;
    end else begin
      st = PAR_BIT | {28'd0, m_ovf, busy_at(cyc - 1), (m_q.size() == 0), (m_q.size() == DEPTH)};
      if (sel && re) m_rdata = (word == 2'd1) ? st : 32'd0;
      pop_now = !busy_at(cyc - 1) && (m_q.size() > 0);
      if (pop_now) begin
        cur_byte = m_q.pop_front();
        last_pop = cyc;
      end
      if (sel && we && word == 2'd0) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(wdata[7:0]);
          exp_q.push_back(wdata[7:0]);
        end else begin
          set_ovf = 1'b1;
        end
      end
      if (sel && we && word == 2'd1 && wdata[3]) m_ovf = 1'b0;
      if (set_ovf) m_ovf = 1'b1;
    end
    #1;
    check("tx", 32'(tx), 32'(model_tx(cyc)));
    check("irq_empty", 32'(irq_empty), 32'((m_q.size() == 0) && !busy_at(cyc)));
    check("rdata", rdata, m_rdata);
  end

  // line receiver: samples mid-bit and scores each frame against exp_q
  logic       rx_busy = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_sh = '0;

  always @(negedge clk) begin : receiver
    int idx;
    if (rst) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (tx == 1'b0) begin
        rx_busy = 1'b1;
        rx_t    = 0;
      end
    end else begin
      rx_t++;
      if ((rx_t % CPB) == CPB / 2) begin
        idx = rx_t / CPB;
        if (idx >= 1 && idx <= 8) rx_sh[idx-1] = tx;
        else if (idx == FB - 1) begin
          rx_busy = 1'b0;
          check("rx_stop", 32'(tx), 32'd1);
          rx_log.push_back(rx_sh);
          check("rx_expected_avail", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) check("rx_byte", 32'(rx_sh), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver tasks: each drives the bus for one cycle starting at a falling edge
  task automatic cycle_write(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
  endtask

  task automatic cycle_read(input logic [AW-1:0] a);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; re = 1'b1; addr = a;
  endtask

  task automatic cycle_idle();
    @(negedge clk);
    sel = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  initial begin
    int w;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset/idle status
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_irq", 32'(irq_empty), 32'd1);
    cycle_read(4'h4);
    cycle_idle();
    check("status_after_reset", rdata, 32'h2 | PAR_BIT);

    // single byte 0xA5
    cycle_write(4'h0, 32'hA5);
    w = cyc + 1;
    cycle_idle();
    check("a5_irq_falls", 32'(irq_empty), 32'd0);
    wait_cyc(w + 1);  check("a5_pre_start", 32'(tx), 32'd1);
    wait_cyc(w + 2);  check("a5_start", 32'(tx), 32'd0);
    wait_cyc(w + 6);  check("a5_bit0", 32'(tx), 32'd1);
    wait_cyc(w + 10); check("a5_bit1", 32'(tx), 32'd0);
    wait_cyc(w + 34); check("a5_bit7", 32'(tx), 32'd1);
    wait_cyc(w + 38); check("a5_after_data", 32'(tx), (FB == 10) ? 32'd1 : 32'd0);
    wait_cyc(w + FL); check("a5_irq_in_stop", 32'(irq_empty), 32'd0);
    wait_cyc(w + 1 + FL); check("a5_irq_rises", 32'(irq_empty), 32'd1);
    wait_cyc(w + FL + 4);

    // ten back-to-back writes: nine accepted, 0x09 dropped
    for (int i = 0; i < 10; i++) cycle_write(4'h0, 32'(i));
    w = cyc - 9;
    cycle_read(4'h4);
    cycle_idle();
    check("status_full_ovf", rdata, 32'hD | PAR_BIT);
    cycle_write(4'h4, 32'h8);
    cycle_read(4'h4);
    cycle_idle();
    check("status_ovf_cleared", rdata, 32'h5 | PAR_BIT);

    // push while full, timed to the next serializer pop edge
    wait_cyc(w + 1 + FL);
    cycle_write(4'h0, 32'h5A);
    cycle_read(4'h4);
    cycle_idle();
    check("status_push_on_pop", rdata, 32'h5 | PAR_BIT);

    wait_cyc(cyc + 10 * (FL + 1) + 8);
    check("rx_count_directed", 32'(rx_log.size()), 32'd11);
    if (rx_log.size() == 11) begin
      check("rx_first", 32'(rx_log[0]), 32'hA5);
      check("rx_byte0", 32'(rx_log[1]), 32'h00);
      check("rx_byte8", 32'(rx_log[9]), 32'h08);
      check("rx_last", 32'(rx_log[10]), 32'h5A);
    end

    // reset during data bit 3 of 0xC3 (bit3 = 0)
    cycle_write(4'h0, 32'hC3);
    w = cyc + 1;
    cycle_write(4'h0, 32'h3C);
    cycle_idle();
    wait_cyc(w + 18);
    check("pre_rst_tx", 32'(tx), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_tx_immediate", 32'(tx), 32'd1);
    check("rst_irq_immediate", 32'(irq_empty), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle_read(4'h4);
    cycle_idle();
    check("status_after_midrst", rdata, 32'h2 | PAR_BIT);
    wait_cyc(cyc + 2 * FL);
    check("no_frames_after_rst", 32'(rx_log.size()), 32'd11);

`ifdef UART_PARITY_EN
    cycle_write(4'h0, 32'h07);
    w = cyc + 1;
    cycle_idle();
    wait_cyc(w + 2 + 9 * CPB);
    check("parity_bit_07", 32'(tx), 32'd1);
    wait_cyc(w + 1 + FL);
    check("parity_frame_end_irq", 32'(irq_empty), 32'd1);
`endif

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      @(negedge clk);
      sel = 1'b1; we = 1'b0; re = 1'b0;
      addr = {2'd0, 2'($urandom_range(0, 3))};
      wdata = $urandom;
      if (r < 30) we = 1'b1;
      else if (r < 40) begin re = 1'b1; addr[3:2] = 2'd1; end
      else if (r < 45) begin we = 1'b1; addr[3:2] = 2'd1; end
      else if (r < 50) begin re = 1'b1; addr[3:2] = 2'($urandom_range(0, 3)); end
      else if (r < 53) begin we = 1'b1; addr[3:2] = 2'($urandom_range(2, 3)); end
      else if (r < 56) begin we = 1'b1; re = 1'b1; addr[3:2] = 2'd1; end
      else if (r < 60) begin sel = 1'b0; we = 1'b1; re = 1'b1; end
      else sel = 1'b0;
    end
    cycle_idle();
    wait_cyc(cyc + (DEPTH + 2) * (FL + 1) + 8);
    check("rx_drained", 32'(exp_q.size()), 32'd0);
    cycle_read(4'h4);
    cycle_idle();
    check("status_final", rdata & 32'h17, 32'h2 | PAR_BIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_mmio_uart_tx.md
Name: riscv_mmio_uart_tx

Overview:
- Memory-mapped console transmitter on the processor's data-memory bus, directly downstream of `riscv_top`.
- Core stores bytes to it; it buffers them in a small FIFO and serialises them as 8N1 UART frames on `tx`.
- Gives the simulation bench a observable output beyond the VCD.
- Single clock domain, same clock as the core.

Parameters:
- CLKS_PER_BIT, 4: clock cycles per UART bit; legal values ≥2.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, ≥2.
- ADDR_W, 4: byte-offset width of the register window.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sel  in  1  bus select, asserted when the core's address hits this window.
- we  in  1  write strobe, valid with sel.
- re  in  1  read strobe, valid with sel.
- addr  in  ADDR_W  byte offset within the window.
- wdata  in  32  store data.
- rdata  out  32  load data, registered.
- tx  out  1  UART serial line, idle high.
- irq_empty  out  1  high while the FIFO is empty and the serializer is idle.

Behaviour:
- Reset: all state is cleared asynchronously.
  - tx=1, rdata=0, irq_empty=1.
  - FIFO empty, pointers 0, overflow flag 0, FSM in IDLE, bit and cycle counters 0.
- Register map, word-aligned; addr[1:0] is ignored.
  - 0x0 TXDATA (write-only). A write pushes wdata[7:0]. Reading returns 0.
  - 0x4 STATUS (read; write-1-to-clear).
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - Writing 1 to wdata[3] clears overflow. Other bits are read-only.
  - Other offsets: reads return 0, writes are ignored.
- Reads: rdata is updated on the clock edge after sel&re, so latency is 1 cycle. rdata holds its value when there is no read.
- STATUS sampling: the value returned reflects state before that edge's push or pop.
- Simultaneous we and re: the write takes effect and the read returns the pre-write value.
- Push acceptance: a push is accepted when the FIFO is not full, or when the serializer pops in the same cycle.
  - Otherwise the byte is dropped and overflow is set the next cycle.
- Overflow set/clear conflict: a simultaneous overflow set and W1C clear leaves overflow=1 (set wins).
- FIFO: synchronous, with count tracking; full when count==FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register and go to START on that edge.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: the shift register's LSB drives tx. Shift right every CLKS_PER_BIT cycles. After 8 bits go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame length and back-to-back frames:
  - One frame is 10·CLKS_PER_BIT cycles.
  - With data still queued there is exactly 1 idle cycle between frames (the IDLE pop cycle).
- First-bit latency: the start bit appears on tx one cycle after the IDLE pop edge. A write to an empty, idle block therefore drives tx low 2 cycles after the write edge.
- irq_empty is combinational from the registered state.
- Reset mid-frame: tx returns to 1 immediately (asynchronously), the frame is abandoned and the FIFO is flushed.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: the FSM gains a PARITY state between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 11·CLKS_PER_BIT cycles.
  - STATUS bit4 reads 1.
- Undefined: no PARITY state, 8N1 framing, STATUS bit4 reads 0.

Decomposition:
- Package `riscv_mmio_pkg`:
  - register offset constants OFF_TXDATA=4'h0, OFF_STATUS=4'h4;
  - STATUS bit-index constants;
  - FSM state enum (2-bit, 3-bit when UART_PARITY_EN).
- Sub-module `riscv_sync_fifo` (parameters WIDTH, DEPTH; push, pop, full, empty, count). It is reusable by a later RX block.
- Serializer FSM and bus decode stay in the top module.

Test Plan:
- Reset, then idle: assert rst for 15 ns, then read STATUS → rdata=0x00000002 (empty); tx=1 throughout; irq_empty=1.
- Single byte 0xA5 to TXDATA (CLKS_PER_BIT=4):
  - tx low starting 2 cycles after the write, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles;
  - irq_empty falls the cycle after the write and rises at the end of STOP.
- Fill to overflow with 10 back-to-back writes (0x00–0x09):
  - STATUS shows full=1 and overflow=1;
  - exactly 9 frames are emitted (1 popped immediately plus 8 buffered), with data 0x00–0x08 in order; 0x09 is dropped;
  - writing 0x8 to STATUS clears overflow.
- Push on full with a simultaneous pop: with the FIFO full, time a write to the IDLE pop cycle → push accepted, overflow stays 0, the byte is transmitted last.
- Reset mid-frame: assert rst during DATA bit 3 → tx=1 within the same cycle, STATUS=0x2 after release, no further frames.
- With UART_PARITY_EN, write 0x07 → the parity bit is 1 and the frame lasts 44 cycles; STATUS bit4=1.
